// File: rtl/br_resolve_pkg.sv
// Shared constants, FSM state type and small helpers for the branch resolution unit.
package br_resolve_pkg;

    localparam logic [2:0] BR_CMP_EQ  = 3'b000;
    localparam logic [2:0] BR_CMP_NE  = 3'b001;
    localparam logic [2:0] BR_CMP_LT  = 3'b100;
    localparam logic [2:0] BR_CMP_GE  = 3'b101;
    localparam logic [2:0] BR_CMP_LTU = 3'b110;
    localparam logic [2:0] BR_CMP_GEU = 3'b111;

    localparam int unsigned RV32_PC_WIDTH   = 32;
    localparam int unsigned RV32_DATA_WIDTH = 32;
    localparam int unsigned ROB_TAG_WIDTH   = 6;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } redirect_state_e;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Saturating accumulate for the statistics counters.
    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [3:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {29'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/br_lane_eval.sv
// Combinational evaluation of one branch lane: condition, target, next PC and mispredict.
module br_lane_eval
    import br_resolve_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = RV32_PC_WIDTH,
    parameter int unsigned DATA_WIDTH = RV32_DATA_WIDTH
) (
    input  logic                  valid_i,
    input  logic                  is_jal_i,
    input  logic                  is_jalr_i,
    input  logic [2:0]            cmp_op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [PC_WIDTH-1:0]   pred_jmpaddr_i,
    output logic                  taken_o,
    output logic [PC_WIDTH-1:0]   next_pc_o,
    output logic                  mispred_o
);

    logic                cmp_true;
    logic                taken_raw;
    logic [PC_WIDTH-1:0] imm_pc;
    logic [PC_WIDTH-1:0] rs1_pc;
    logic [PC_WIDTH-1:0] jalr_sum;
    logic [PC_WIDTH-1:0] target;

    always_comb begin
        cmp_true = 1'b0;
        case (cmp_op_i)
            BR_CMP_EQ:  cmp_true = (rs1_i == rs2_i);
            BR_CMP_NE:  cmp_true = (rs1_i != rs2_i);
            BR_CMP_LT:  cmp_true = ($signed(rs1_i) < $signed(rs2_i));
            BR_CMP_GE:  cmp_true = ($signed(rs1_i) >= $signed(rs2_i));
            BR_CMP_LTU: cmp_true = (rs1_i < rs2_i);
            BR_CMP_GEU: cmp_true = (rs1_i >= rs2_i);
            default:    cmp_true = 1'b0;
        endcase
    end

    // Offsets are signed, so widen them with sign extension into the PC domain.
    assign imm_pc    = PC_WIDTH'($signed(imm_i));
    assign rs1_pc    = PC_WIDTH'(rs1_i);
    assign jalr_sum  = rs1_pc + imm_pc;
    assign target    = is_jalr_i ? {jalr_sum[PC_WIDTH-1:1], 1'b0} : (pc_i + imm_pc);

    assign taken_raw = is_jal_i | is_jalr_i | cmp_true;
    assign next_pc_o = taken_raw ? target : (pc_i + PC_WIDTH'(4));
    assign taken_o   = valid_i & taken_raw;
    assign mispred_o = valid_i & (next_pc_o != pred_jmpaddr_i);

endmodule

// File: rtl/br_resolve.sv
// Multi-lane branch resolution with a single oldest-first redirect slot.
// Optional statistics counters are built when BR_RESOLVE_STATS_EN is defined.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned TAG_WIDTH  = ROB_TAG_WIDTH,
    parameter int unsigned PC_WIDTH   = RV32_PC_WIDTH,
    parameter int unsigned DATA_WIDTH = RV32_DATA_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic [TAG_WIDTH-1:0]            i_rob_head_tag,
    input  logic [NUM_LANES-1:0]            i_valid,
    input  logic [NUM_LANES-1:0]            i_is_jal,
    input  logic [NUM_LANES-1:0]            i_is_jalr,
    input  logic [NUM_LANES*3-1:0]          i_cmp_op,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] i_rs1,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] i_rs2,
    input  logic [NUM_LANES*PC_WIDTH-1:0]   i_pc,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] i_imm,
    input  logic [NUM_LANES*PC_WIDTH-1:0]   i_pred_jmpaddr,
    input  logic [NUM_LANES*TAG_WIDTH-1:0]  i_tag,
    output logic [NUM_LANES-1:0]            o_res_valid,
    output logic [NUM_LANES*TAG_WIDTH-1:0]  o_res_tag,
    output logic [NUM_LANES-1:0]            o_res_taken,
    output logic [NUM_LANES*PC_WIDTH-1:0]   o_res_jmpaddr,
    output logic [NUM_LANES-1:0]            o_res_mispred,
    output logic                            o_redirect_valid,
    output logic [PC_WIDTH-1:0]             o_redirect_pc,
    output logic [TAG_WIDTH-1:0]            o_redirect_tag,
    input  logic                            i_redirect_ready,
    output logic [31:0]                     o_stat_resolved,
    output logic [31:0]                     o_stat_mispred
);

    logic [NUM_LANES-1:0]          lane_valid;
    logic [NUM_LANES-1:0]          lane_taken;
    logic [NUM_LANES-1:0]          lane_mispred;
    logic [NUM_LANES*PC_WIDTH-1:0] lane_next;
    logic [TAG_WIDTH-1:0]          lane_age [NUM_LANES];

    // A flush kills this cycle's inputs before they reach results, slot or counters.
    assign lane_valid = i_valid & {NUM_LANES{~i_flush}};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        br_lane_eval #(
            .PC_WIDTH  (PC_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane_eval (
            .valid_i       (lane_valid[l]),
            .is_jal_i      (i_is_jal[l]),
            .is_jalr_i     (i_is_jalr[l]),
            .cmp_op_i      (i_cmp_op[l*3 +: 3]),
            .rs1_i         (i_rs1[l*DATA_WIDTH +: DATA_WIDTH]),
            .rs2_i         (i_rs2[l*DATA_WIDTH +: DATA_WIDTH]),
            .imm_i         (i_imm[l*DATA_WIDTH +: DATA_WIDTH]),
            .pc_i          (i_pc[l*PC_WIDTH +: PC_WIDTH]),
            .pred_jmpaddr_i(i_pred_jmpaddr[l*PC_WIDTH +: PC_WIDTH]),
            .taken_o       (lane_taken[l]),
            .next_pc_o     (lane_next[l*PC_WIDTH +: PC_WIDTH]),
            .mispred_o     (lane_mispred[l])
        );

        assign lane_age[l] = i_tag[l*TAG_WIDTH +: TAG_WIDTH] - i_rob_head_tag;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid   <= '0;
            o_res_tag     <= '0;
            o_res_taken   <= '0;
            o_res_jmpaddr <= '0;
            o_res_mispred <= '0;
        end else begin
            o_res_valid   <= lane_valid;
            o_res_tag     <= i_tag;
            o_res_taken   <= lane_taken;
            o_res_jmpaddr <= lane_next;
            o_res_mispred <= lane_mispred;
        end
    end

    // Oldest mispredicting lane; strict compare keeps the lowest lane on ties.
    logic                 cand_valid;
    logic [TAG_WIDTH-1:0] cand_age;
    logic [TAG_WIDTH-1:0] cand_tag;
    logic [PC_WIDTH-1:0]  cand_pc;

    always_comb begin
        cand_valid = 1'b0;
        cand_age   = '0;
        cand_tag   = '0;
        cand_pc    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_mispred[l] && (!cand_valid || (lane_age[l] < cand_age))) begin
                cand_valid = 1'b1;
                cand_age   = lane_age[l];
                cand_tag   = i_tag[l*TAG_WIDTH +: TAG_WIDTH];
                cand_pc    = lane_next[l*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    redirect_state_e      state_q, state_d;
    logic [PC_WIDTH-1:0]  slot_pc_q;
    logic [TAG_WIDTH-1:0] slot_tag_q;
    logic [TAG_WIDTH-1:0] slot_age;
    logic                 cand_older;
    logic                 slot_load;

    // Slot age is re-derived every cycle because the ROB head keeps moving.
    assign slot_age   = slot_tag_q - i_rob_head_tag;
    assign cand_older = cand_valid && (cand_age < slot_age);

    always_comb begin
        state_d   = state_q;
        slot_load = 1'b0;
        case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    state_d   = StPending;
                    slot_load = 1'b1;
                end
            end
            StPending: begin
                slot_load = cand_older;
                if (i_redirect_ready && !cand_older) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_flush) begin
            state_d   = StIdle;
            slot_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            slot_pc_q  <= '0;
            slot_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (slot_load) begin
                slot_pc_q  <= cand_pc;
                slot_tag_q <= cand_tag;
            end
        end
    end

    assign o_redirect_valid = (state_q == StPending);
    assign o_redirect_pc    = slot_pc_q;
    assign o_redirect_tag   = slot_tag_q;

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= sat_add(stat_resolved_q, count_ones(8'(lane_valid)));
            stat_mispred_q  <= sat_add(stat_mispred_q, count_ones(8'(lane_mispred)));
        end
    end

    assign o_stat_resolved = stat_resolved_q;
    assign o_stat_mispred  = stat_mispred_q;
`else
    assign o_stat_resolved = '0;
    assign o_stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: directed vector table, corner sequences, random traffic.
module tb_br_resolve;

    localparam int NL = 2;
    localparam int TW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic          ready;
    logic [TW-1:0] head;

    logic [NL-1:0] t_valid, t_jal, t_jalr;
    logic [2:0]    t_op   [NL];
    logic [31:0]   t_rs1  [NL];
    logic [31:0]   t_rs2  [NL];
    logic [31:0]   t_pc   [NL];
    logic [31:0]   t_imm  [NL];
    logic [31:0]   t_pred [NL];
    logic [TW-1:0] t_tag  [NL];

    logic [NL*3-1:0]  op_bus;
    logic [NL*32-1:0] rs1_bus, rs2_bus, pc_bus, imm_bus, pred_bus;
    logic [NL*TW-1:0] tag_bus;

    logic [NL-1:0]    o_res_valid, o_res_taken, o_res_mispred;
    logic [NL*TW-1:0] o_res_tag;
    logic [NL*32-1:0] o_res_jmpaddr;
    logic             o_redirect_valid;
    logic [31:0]      o_redirect_pc;
    logic [TW-1:0]    o_redirect_tag;
    logic [31:0]      o_stat_resolved, o_stat_mispred;

    for (genvar l = 0; l < NL; l++) begin : g_pack
        assign op_bus[l*3 +: 3]    = t_op[l];
        assign rs1_bus[l*32 +: 32] = t_rs1[l];
        assign rs2_bus[l*32 +: 32] = t_rs2[l];
        assign pc_bus[l*32 +: 32]  = t_pc[l];
        assign imm_bus[l*32 +: 32] = t_imm[l];
        assign pred_bus[l*32 +: 32] = t_pred[l];
        assign tag_bus[l*TW +: TW] = t_tag[l];
    end

    br_resolve #(
        .NUM_LANES (NL),
        .TAG_WIDTH (TW),
        .PC_WIDTH  (32),
        .DATA_WIDTH(32)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_rob_head_tag  (head),
        .i_valid         (t_valid),
        .i_is_jal        (t_jal),
        .i_is_jalr       (t_jalr),
        .i_cmp_op        (op_bus),
        .i_rs1           (rs1_bus),
        .i_rs2           (rs2_bus),
        .i_pc            (pc_bus),
        .i_imm           (imm_bus),
        .i_pred_jmpaddr  (pred_bus),
        .i_tag           (tag_bus),
        .o_res_valid     (o_res_valid),
        .o_res_tag       (o_res_tag),
        .o_res_taken     (o_res_taken),
        .o_res_jmpaddr   (o_res_jmpaddr),
        .o_res_mispred   (o_res_mispred),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc   (o_redirect_pc),
        .o_redirect_tag  (o_redirect_tag),
        .i_redirect_ready(ready),
        .o_stat_resolved (o_stat_resolved),
        .o_stat_mispred  (o_stat_mispred)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: the pending redirect and the event counts.
    bit            m_pend;
    logic [31:0]   m_pc;
    logic [TW-1:0] m_tag;
    logic [31:0]   m_sres, m_smis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int age_of(input logic [TW-1:0] tag, input logic [TW-1:0] h);
        return (int'(tag) - int'(h) + 64) % 64;
    endfunction

    function automatic void lane_ref(input int l, output bit tk, output logic [31:0] nx,
                                     output bit ms);
        bit c;
        logic [31:0] tgt;
        case (t_op[l])
            3'd0:    c = (t_rs1[l] == t_rs2[l]);
            3'd1:    c = (t_rs1[l] != t_rs2[l]);
            3'd4:    c = ($signed(t_rs1[l]) < $signed(t_rs2[l]));
            3'd5:    c = ($signed(t_rs1[l]) >= $signed(t_rs2[l]));
            3'd6:    c = (t_rs1[l] < t_rs2[l]);
            3'd7:    c = (t_rs1[l] >= t_rs2[l]);
            default: c = 1'b0;
        endcase
        tk  = t_jal[l] | t_jalr[l] | c;
        tgt = t_jalr[l] ? ((t_rs1[l] + t_imm[l]) & 32'hFFFF_FFFE) : (t_pc[l] + t_imm[l]);
        nx  = tk ? tgt : (t_pc[l] + 32'd4);
        ms  = t_valid[l] && (nx != t_pred[l]);
    endfunction

    task automatic idle_inputs();
        flush   = 1'b0;
        t_valid = '0;
        t_jal   = '0;
        t_jalr  = '0;
        for (int l = 0; l < NL; l++) begin
            t_op[l] = 3'd0; t_rs1[l] = '0; t_rs2[l] = '0; t_pc[l] = '0;
            t_imm[l] = '0; t_pred[l] = '0; t_tag[l] = '0;
        end
    endtask

    task automatic set_lane(input int l, input logic [2:0] op, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] pred,
                            input logic [TW-1:0] tag);
        t_valid[l] = 1'b1; t_jal[l] = 1'b0; t_jalr[l] = 1'b0;
        t_op[l] = op; t_rs1[l] = rs1; t_rs2[l] = rs2; t_pc[l] = pc;
        t_imm[l] = imm; t_pred[l] = pred; t_tag[l] = tag;
    endtask

    task automatic chk_stats();
`ifdef BR_RESOLVE_STATS_EN
        chk("stat_resolved", o_stat_resolved, m_sres);
        chk("stat_mispred", o_stat_mispred, m_smis);
`else
        chk("stat_resolved", o_stat_resolved, 32'd0);
        chk("stat_mispred", o_stat_mispred, 32'd0);
`endif
    endtask

    // One clock: predict from the spec rules, advance, compare.
    task automatic step();
        bit          tk [NL];
        logic [31:0] nx [NL];
        bit          ms [NL];
        int best, best_age, nres, nmis;
        bit cand_ok;
        best = -1; best_age = 0; nres = 0; nmis = 0;
        for (int l = 0; l < NL; l++) begin
            lane_ref(l, tk[l], nx[l], ms[l]);
            if (!flush && t_valid[l]) nres++;
            if (!flush && ms[l]) begin
                nmis++;
                if (best < 0 || age_of(t_tag[l], head) < best_age) begin
                    best = l;
                    best_age = age_of(t_tag[l], head);
                end
            end
        end
        cand_ok = (best >= 0) && (!m_pend || best_age < age_of(m_tag, head));
        if (flush) m_pend = 1'b0;
        else if (cand_ok) begin
            m_pend = 1'b1; m_pc = nx[best]; m_tag = t_tag[best];
        end else if (!(m_pend && !ready)) m_pend = 1'b0;
        if (!flush) begin
            m_sres += 32'(nres);
            m_smis += 32'(nmis);
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("res_valid[%0d]", l), o_res_valid[l], t_valid[l] & ~flush);
            chk($sformatf("res_mispred[%0d]", l), o_res_mispred[l], ms[l] & ~flush);
            if (t_valid[l] && !flush) begin
                chk($sformatf("res_taken[%0d]", l), o_res_taken[l], tk[l]);
                chk($sformatf("res_jmpaddr[%0d]", l), o_res_jmpaddr[l*32 +: 32], nx[l]);
                chk($sformatf("res_tag[%0d]", l), o_res_tag[l*TW +: TW], t_tag[l]);
            end
        end
        chk("redirect_valid", o_redirect_valid, m_pend);
        if (m_pend) begin
            chk("redirect_pc", o_redirect_pc, m_pc);
            chk("redirect_tag", o_redirect_tag, m_tag);
        end
        chk_stats();
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'hFFFF_FFFF;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    typedef struct {
        int          lane;
        logic        jal;
        logic        jalr;
        logic [2:0]  op;
        logic [31:0] rs1, rs2, pc, imm, pred;
        logic        exp_taken;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t vt [9];
    logic [31:0] s_res, s_mis;

    initial begin
        vt[0] = '{0, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 32'h104,
                  1'b1, 32'h120, 1'b1};
        vt[1] = '{1, 1'b0, 1'b1, 3'b000, 32'h2001, 32'd0, 32'h50, 32'd2, 32'h2002,
                  1'b1, 32'h2002, 1'b0};
        vt[2] = '{0, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h204,
                  1'b0, 32'h204, 1'b0};
        vt[3] = '{1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'hFFFF_FFF8,
                  32'h304, 1'b1, 32'h2F8, 1'b1};
        vt[4] = '{0, 1'b0, 1'b0, 3'b001, 32'd3, 32'd3, 32'h400, 32'h10, 32'h410,
                  1'b0, 32'h404, 1'b1};
        vt[5] = '{1, 1'b0, 1'b0, 3'b010, 32'd7, 32'd7, 32'h500, 32'h10, 32'h504,
                  1'b0, 32'h504, 1'b0};
        vt[6] = '{0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd1, 32'hFFFF_FFF0, 32'h20, 32'h10,
                  1'b1, 32'h10, 1'b0};
        vt[7] = '{1, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'd0, 32'h600, 32'h40, 32'h640,
                  1'b0, 32'h604, 1'b1};
        vt[8] = '{0, 1'b0, 1'b0, 3'b111, 32'h8000_0000, 32'd0, 32'h700, 32'h8, 32'h708,
                  1'b1, 32'h708, 1'b0};

        rst_n = 1'b0; ready = 1'b0; head = '0;
        m_pend = 1'b0; m_pc = '0; m_tag = '0; m_sres = '0; m_smis = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", o_res_valid, '0);
        chk("rst_res_taken", o_res_taken, '0);
        chk("rst_res_mispred", o_res_mispred, '0);
        chk("rst_res_jmpaddr", o_res_jmpaddr, '0);
        chk("rst_res_tag", o_res_tag, '0);
        chk("rst_redirect_valid", o_redirect_valid, 1'b0);
        chk("rst_redirect_pc", o_redirect_pc, '0);
        chk("rst_redirect_tag", o_redirect_tag, '0);
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table, each followed by a draining idle cycle.
        foreach (vt[i]) begin
            idle_inputs();
            ready = 1'b0;
            set_lane(vt[i].lane, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].pc, vt[i].imm,
                     vt[i].pred, '0);
            t_jal[vt[i].lane]  = vt[i].jal;
            t_jalr[vt[i].lane] = vt[i].jalr;
            step();
            chk($sformatf("vec%0d_taken", i), o_res_taken[vt[i].lane], vt[i].exp_taken);
            chk($sformatf("vec%0d_addr", i), o_res_jmpaddr[vt[i].lane*32 +: 32], vt[i].exp_addr);
            chk($sformatf("vec%0d_mispred", i), o_res_mispred[vt[i].lane], vt[i].exp_mis);
            chk($sformatf("vec%0d_rvalid", i), o_redirect_valid, vt[i].exp_mis);
            if (vt[i].exp_mis) chk($sformatf("vec%0d_rpc", i), o_redirect_pc, vt[i].exp_addr);
            idle_inputs();
            ready = 1'b1;
            step();
            chk($sformatf("vec%0d_drain", i), o_redirect_valid, 1'b0);
        end

        // Age wraps around the ROB head: tag 62 is older than tag 2 when head is 60.
        idle_inputs(); ready = 1'b0; head = 6'd60;
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h1000, 32'h10, 32'h1004, 6'd2);
        set_lane(1, 3'b000, 32'd1, 32'd1, 32'h2000, 32'h20, 32'h2004, 6'd62);
        step();
        chk("wrap_tag", o_redirect_tag, 6'd62);
        chk("wrap_pc", o_redirect_pc, 32'h2020);
        idle_inputs(); ready = 1'b1; step();

        // Older candidate replaces a stalled slot; a younger one is ignored.
        head = '0; ready = 1'b0; idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h3000, 32'h40, 32'h3004, 6'd10);
        step();
        chk("repl_first_tag", o_redirect_tag, 6'd10);
        idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h3100, 32'h40, 32'h3104, 6'd5);
        step();
        chk("repl_older_tag", o_redirect_tag, 6'd5);
        chk("repl_older_valid", o_redirect_valid, 1'b1);
        idle_inputs();
        set_lane(1, 3'b000, 32'd1, 32'd1, 32'h3200, 32'h40, 32'h3204, 6'd20);
        step();
        chk("repl_young_tag", o_redirect_tag, 6'd5);
        chk("repl_young_pc", o_redirect_pc, 32'h3140);
        idle_inputs(); ready = 1'b1; step();
        chk("repl_retire", o_redirect_valid, 1'b0);

        // Retire with a same-cycle older candidate, then with a younger one.
        ready = 1'b0; idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h4000, 32'h40, 32'h4004, 6'd10);
        step();
        idle_inputs(); ready = 1'b1;
        set_lane(1, 3'b000, 32'd1, 32'd1, 32'h4100, 32'h40, 32'h4104, 6'd3);
        step();
        chk("retire_older_valid", o_redirect_valid, 1'b1);
        chk("retire_older_tag", o_redirect_tag, 6'd3);
        chk("retire_older_pc", o_redirect_pc, 32'h4140);
        idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h4200, 32'h40, 32'h4204, 6'd30);
        step();
        chk("retire_younger_valid", o_redirect_valid, 1'b0);

        // Flush while pending, together with a fresh mispredict.
        ready = 1'b0; idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h5000, 32'h40, 32'h5004, 6'd10);
        step();
        s_res = o_stat_resolved; s_mis = o_stat_mispred;
        idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h5100, 32'h40, 32'h5104, 6'd5);
        set_lane(1, 3'b000, 32'd1, 32'd1, 32'h5200, 32'h40, 32'h5204, 6'd6);
        flush = 1'b1;
        step();
        chk("flush_rvalid", o_redirect_valid, 1'b0);
        chk("flush_res_valid", o_res_valid, '0);
        chk("flush_stat_resolved", o_stat_resolved, s_res);
        chk("flush_stat_mispred", o_stat_mispred, s_mis);
        idle_inputs(); step();

        // Asynchronous reset in the middle of a pending redirect.
        ready = 1'b0; idle_inputs();
        set_lane(0, 3'b000, 32'd1, 32'd1, 32'h6000, 32'h40, 32'h6004, 6'd12);
        step();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", o_redirect_valid, 1'b0);
        chk("async_rst_res_valid", o_res_valid, '0);
        chk("async_rst_rtag", o_redirect_tag, '0);
        m_pend = 1'b0; m_pc = '0; m_tag = '0; m_sres = '0; m_smis = '0;
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            int off0, off1;
            idle_inputs();
            if ($urandom_range(0, 9) == 0) head = 6'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            ready = $urandom_range(0, 1) == 1;
            off0 = $urandom_range(0, 62);
            off1 = (off0 + 1 + $urandom_range(0, 61)) % 63;
            for (int l = 0; l < NL; l++) begin
                t_valid[l] = $urandom_range(0, 3) != 0;
                case ($urandom_range(0, 7))
                    0: t_jal[l] = 1'b1;
                    1: t_jalr[l] = 1'b1;
                    default: ;
                endcase
                t_op[l]  = 3'($urandom_range(0, 7));
                t_rs1[l] = pick_val();
                t_rs2[l] = pick_val();
                t_pc[l]  = $urandom & 32'hFFFF_FFFC;
                t_imm[l] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255))
                                                       : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
                case ($urandom_range(0, 2))
                    0: t_pred[l] = t_pc[l] + 32'd4;
                    1: t_pred[l] = t_pc[l] + t_imm[l];
                    default: t_pred[l] = $urandom;
                endcase
                t_tag[l] = head + 6'((l == 0) ? off0 : off1);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
